// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the two-entry skid pipeline stage: occupancy
// state encoding, default word width and an occupancy helper.
package pipe_skid_stage_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occ_of(input logic main_vld, input logic skid_vld);
        return {1'b0, main_vld} + {1'b0, skid_vld};
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream and downstream valid/ready handshake of the skid stage.
// The slave modport is the stage itself; the master modport is its environment.
interface pipe_skid_stage_if
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_rdy;

    modport slave (
        input  in_data, in_vld, out_rdy,
        output in_rdy, out_data, out_vld
    );

    modport master (
        output in_data, in_vld, out_rdy,
        input  in_rdy, out_data, out_vld
    );
endinterface

// File: rtl/pipe_skid_stage_reg_en_vec.sv
// Vector enable register: hold=1 keeps the stored word, hold=0 loads d.
module reg_en_vec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_r;

    // Storage flop with hold-select enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r <= '0;
        end else if (!hold) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage: downstream backpressure becomes hold
// selects on the main/skid registers, and in_rdy comes only from flops.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                clk,
    input  logic                rstn,
    pipe_skid_stage_if.slave    bus,
    input  logic                flush,
    output logic [1:0]          occ
);
    skid_state_e      state_r;
    skid_state_e      state_s;
    logic             main_vld_r;
    logic             skid_vld_r;
    logic             in_rdy_r;
    logic [1:0]       occ_r;
    logic             main_vld_s;
    logic             skid_vld_s;
    logic             main_hold_s;
    logic             skid_hold_s;
    logic             main_sel_skid_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    assign in_xfer_s  = bus.in_vld & in_rdy_r;
    assign out_xfer_s = main_vld_r & bus.out_rdy;
    assign main_d_s   = main_sel_skid_s ? skid_q_s : bus.in_data;

    // Next occupancy state and the hold selects / main load source.
    always_comb begin
        state_s         = state_r;
        main_hold_s     = 1'b1;
        skid_hold_s     = 1'b1;
        main_sel_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    main_hold_s = 1'b0;
                    state_s     = ST_ONE;
                end else begin
                    state_s     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    main_hold_s = 1'b0;
                    state_s     = ST_ONE;
                end else if (in_xfer_s) begin
                    skid_hold_s = 1'b0;
                    state_s     = ST_FULL;
                end else if (out_xfer_s) begin
                    state_s     = ST_EMPTY;
                end else begin
                    state_s     = ST_ONE;
                end
            end
            ST_FULL: begin
                // Refill main from skid; in_rdy is low so nothing new enters.
                if (out_xfer_s) begin
                    main_hold_s     = 1'b0;
                    main_sel_skid_s = 1'b1;
                    state_s         = ST_ONE;
                end else begin
                    state_s         = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_s     = ST_EMPTY;
            main_hold_s = 1'b1;
            skid_hold_s = 1'b1;
        end else begin
            state_s     = state_s;
        end
    end

    // Valid bits implied by the next state.
    always_comb begin
        main_vld_s = (state_s != ST_EMPTY);
        skid_vld_s = (state_s == ST_FULL);
    end

    // State, valid bits and registered handshake/debug outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_EMPTY;
            main_vld_r <= 1'b0;
            skid_vld_r <= 1'b0;
            in_rdy_r   <= 1'b1;
            occ_r      <= 2'd0;
        end else begin
            state_r    <= state_s;
            main_vld_r <= main_vld_s;
            skid_vld_r <= skid_vld_s;
            in_rdy_r   <= ~skid_vld_s;
            occ_r      <= occ_of(main_vld_s, skid_vld_s);
        end
    end

    reg_en_vec #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rstn (rstn),
        .hold (main_hold_s),
        .d    (main_d_s),
        .q    (main_q_s)
    );

    reg_en_vec #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rstn (rstn),
        .hold (skid_hold_s),
        .d    (bus.in_data),
        .q    (skid_q_s)
    );

    assign bus.in_rdy   = in_rdy_r;
    assign bus.out_vld  = main_vld_r;
    assign bus.out_data = main_q_s;
    assign occ          = occ_r;

    logic unused_s;
    assign unused_s = skid_vld_r;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a two-deep FIFO queue model.
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] occ;
    int         vectors;
    int         miscompares;
    logic [15:0] q[$];

    pipe_skid_stage_if #(.WIDTH(16)) bus ();

    pipe_skid_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .flush (flush),
        .occ   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs with the queue model (call away from posedge).
    task automatic check_model();
        check("out_vld", 32'(bus.out_vld), 32'(q.size() > 0));
        check("in_rdy", 32'(bus.in_rdy), 32'(q.size() < 2));
        check("occ", 32'(occ), 32'(q.size()));
        if (q.size() > 0) check("out_data", 32'(bus.out_data), 32'(q[0]));
    endtask

    // One clock: check, drive, advance the model on the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic f);
        logic ix;
        logic ox;
        check_model();
        bus.in_vld  = v;
        bus.in_data = d;
        bus.out_rdy = r;
        flush       = f;
        ix = v && (q.size() < 2);
        ox = (q.size() > 0) && r;
        @(posedge clk);
        if (ox) void'(q.pop_front());
        if (f) q.delete();
        else if (ix) q.push_back(d);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        flush       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = 16'h0000;
        bus.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b1, 1'b0);
            check("stream_in_rdy", 32'(bus.in_rdy), 32'd1);
            check("stream_data", 32'(bus.out_data), 32'(i));
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure fill, rejected offer, then drain
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0);
        check("bp_occ", 32'(occ), 32'd2);
        check("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("bp_hold", 32'(bus.out_data), 32'hAAAA);
        step(1'b1, 16'hCCCC, 1'b0, 1'b0);
        check("bp_reject_occ", 32'(occ), 32'd2);
        check("bp_still", 32'(bus.out_data), 32'hAAAA);
        step(1'b1, 16'hCCCC, 1'b1, 1'b0);
        check("bp_second", 32'(bus.out_data), 32'hBBBB);
        step(1'b1, 16'hCCCC, 1'b1, 1'b0);
        check("bp_third", 32'(bus.out_data), 32'hCCCC);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous accept and deliver at occ=1
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b1, 1'b0);
        check("sim_occ", 32'(occ), 32'd1);
        check("sim_data", 32'(bus.out_data), 32'h2222);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush with a coincident offer
        step(1'b1, 16'h4444, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b1);
        check("flush_occ", 32'(occ), 32'd0);
        check("flush_vld", 32'(bus.out_vld), 32'd0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("flush_no_3333", 32'(bus.out_vld), 32'd0);

        // Reset mid-stream with two entries held
        step(1'b1, 16'h6666, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b0);
        check("pre_rst_occ", 32'(occ), 32'd2);
        rstn = 1'b0;
        #1;
        check("mid_rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("mid_rst_occ", 32'(occ), 32'd0);
        q.delete();
        bus.in_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom()),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
